// File: rtl/pulse_generator_multi.sv
// Multi-channel input conditioner: synchroniser, glitch filter, edge select and retriggerable pulse stretch.
// Define EDGE_COUNT_EN to add per-channel saturating qualifying-edge counters.

module pulse_gen_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_signal,
    input  logic [1:0]           i_mode,
    input  logic                 i_count_clear,
    output logic                 o_pulse,
    output logic                 o_pulse_nxt,
    output logic                 o_level,
    output logic [CNT_WIDTH-1:0] o_edge_count
);
    localparam logic [7:0] FC_MAX  = 8'(FILTER_LEN - 1);
    localparam logic [7:0] SC_LOAD = 8'(PULSE_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [7:0]             r_fc;
    logic [7:0]             r_sc;
    logic                   r_level;
    logic                   r_pulse;
    logic                   w_s;
    logic                   w_event;
    logic                   w_qual;

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_event = (w_s != r_level) && (r_fc == FC_MAX);
    // mode bit 0 enables rising events, bit 1 falling events
    assign w_qual  = w_event && (w_s ? i_mode[0] : i_mode[1]);
    assign o_pulse_nxt = w_qual || (r_sc != 8'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_fc    <= 8'd0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};
            if (w_s == r_level) begin
                r_fc <= 8'd0;
            end else if (r_fc == FC_MAX) begin
                r_level <= w_s;
                r_fc    <= 8'd0;
            end else begin
                r_fc <= r_fc + 8'd1;
            end
        end
    end

    // A qualifying event reloads the stretch counter, so pulses extend rather than split
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sc    <= 8'd0;
            r_pulse <= 1'b0;
        end else begin
            if (w_qual)
                r_sc <= SC_LOAD;
            else if (r_sc != 8'd0)
                r_sc <= r_sc - 8'd1;
            r_pulse <= o_pulse_nxt;
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

`ifdef EDGE_COUNT_EN
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_count_clear)
            r_cnt <= '0;
        else if (w_qual && (r_cnt != {CNT_WIDTH{1'b1}}))
            r_cnt <= r_cnt + CNT_WIDTH'(1);
    end

    assign o_edge_count = r_cnt;
`else
    logic w_unused_clear;
    assign w_unused_clear = i_count_clear;
    assign o_edge_count   = '0;
`endif
endmodule

module pulse_generator_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           signal,
    input  logic [2*CHANNELS-1:0]         mode,
    output logic [CHANNELS-1:0]           pulse,
    output logic [CHANNELS-1:0]           level,
    output logic                          any_pulse,
    input  logic                          count_clear,
    output logic [CNT_WIDTH*CHANNELS-1:0] edge_count
);
    logic [CHANNELS-1:0] w_pulse_nxt;
    logic                r_any_pulse;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_gen_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .PULSE_LEN   (PULSE_LEN),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_ch (
            .clock         (clock),
            .reset_n       (reset_n),
            .i_signal      (signal[i]),
            .i_mode        (mode[2*i +: 2]),
            .i_count_clear (count_clear),
            .o_pulse       (pulse[i]),
            .o_pulse_nxt   (w_pulse_nxt[i]),
            .o_level       (level[i]),
            .o_edge_count  (edge_count[CNT_WIDTH*i +: CNT_WIDTH])
        );
    end

    // Built from next-state pulses so it lines up with the pulse register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_any_pulse <= 1'b0;
        else
            r_any_pulse <= |w_pulse_nxt;
    end

    assign any_pulse = r_any_pulse;
endmodule

// File: tb/tb_pulse_generator_multi.sv
// Bench for pulse_generator_multi: defaults instance (a) plus FILTER_LEN=1/PULSE_LEN=4 instance (b).
module tb_pulse_generator_multi;
    localparam int CH = 4;
    localparam int CW = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              count_clear = 1'b0;
    logic [CH-1:0]     sig_a = '0, sig_b = '0;
    logic [2*CH-1:0]   mode_a = '0, mode_b = '0;
    logic [CH-1:0]     pulse_a, pulse_b, level_a, level_b;
    logic              any_a, any_b;
    logic [CW*CH-1:0]  ec_a, ec_b;

    always #5 clock = ~clock;

    pulse_generator_multi dut_a (
        .clock(clock), .reset_n(reset_n), .signal(sig_a), .mode(mode_a),
        .pulse(pulse_a), .level(level_a), .any_pulse(any_a),
        .count_clear(count_clear), .edge_count(ec_a)
    );

    pulse_generator_multi #(.FILTER_LEN(1), .PULSE_LEN(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .signal(sig_b), .mode(mode_b),
        .pulse(pulse_b), .level(level_b), .any_pulse(any_b),
        .count_clear(count_clear), .edge_count(ec_b)
    );

    typedef struct { int cyc; bit b; logic [3:0] p; logic [3:0] l; logic a; } exp_t;
    typedef struct { logic [3:0] sig; logic [3:0] p; logic [3:0] l; logic a; } vec_t;

    exp_t sbq[$];
    vec_t tbl[41];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    function automatic void push(int at, bit b, logic [3:0] p, logic [3:0] l, logic a);
        exp_t e;
        e.cyc = at; e.b = b; e.p = p; e.l = l; e.a = a;
        sbq.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one edge, then retire every scoreboard entry due at this edge
    task automatic tick();
        exp_t e;
        logic [8:0] act;
        @(posedge clock);
        #1;
        cyc++;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            act = e.b ? {pulse_b, level_b, any_b} : {pulse_a, level_a, any_a};
            checks++;
            if (e.cyc != cyc || act !== {e.p, e.l, e.a}) begin
                errors++;
                $display("FAIL sb dut_%s cyc=%0d: got p=%b l=%b a=%b expected p=%b l=%b a=%b (due %0d)",
                         e.b ? "b" : "a", cyc, act[8:5], act[4:1], act[0], e.p, e.l, e.a, e.cyc);
            end
        end
    endtask

    initial begin
        // Channel map for dut_a: ch0 falling, ch1 rising, ch2 both, ch3 none
        for (int t = 0; t < 41; t++) tbl[t] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[0].sig = 4'b0010; tbl[1].sig = 4'b0010;                 // 2-cycle glitch on ch1
        for (int t = 7; t <= 9; t++)   tbl[t].sig = 4'b0010;        // 3-cycle pulse on ch1
        for (int t = 15; t <= 22; t++) tbl[t].sig = 4'b1111;        // all channels together
        tbl[31].sig = 4'b0100; tbl[32].sig = 4'b0100;               // interrupted run on ch2
        tbl[34].sig = 4'b0100; tbl[35].sig = 4'b0100;
        tbl[11].p = 4'b0010; tbl[11].a = 1'b1;
        for (int t = 11; t <= 13; t++) tbl[t].l = 4'b0010;
        tbl[19].p = 4'b0110; tbl[19].a = 1'b1;
        for (int t = 19; t <= 26; t++) tbl[t].l = 4'b1111;
        tbl[27].p = 4'b0101; tbl[27].a = 1'b1;

        // Reset state
        #3;
        chk("rst_pulse_a", 32'(pulse_a), 0); chk("rst_level_a", 32'(level_a), 0);
        chk("rst_any_a", 32'(any_a), 0);     chk("rst_ec_a", ec_a, 0);
        chk("rst_pulse_b", 32'(pulse_b), 0); chk("rst_level_b", 32'(level_b), 0);
        tick(); tick();
        mode_a = 8'b00_11_01_10;
        reset_n = 1'b1;
        repeat (6) tick();

        // Tests 2 and 4: table vectors on dut_a
        for (int t = 0; t < 41; t++) begin
            sig_a = tbl[t].sig;
            push(cyc + 1, 1'b0, tbl[t].p, tbl[t].l, tbl[t].a);
            tick();
        end

        // Test 1: ch0 high 20 cycles then low, falling-only mode
        for (int r = 0; r < 30; r++) begin
            sig_a = (r < 20) ? 4'b0001 : 4'b0000;
            push(cyc + 1, 1'b0, (r == 24) ? 4'b0001 : 4'b0000,
                 (r >= 4 && r <= 23) ? 4'b0001 : 4'b0000, r == 24);
            tick();
        end

        // Test 3: retrigger on dut_b ch0 (both edges), edges 2 apart
        mode_b = 8'b00_00_00_11;
        for (int r = 0; r < 12; r++) begin
            sig_b = (r < 2) ? 4'b0001 : 4'b0000;
            push(cyc + 1, 1'b1, (r >= 2 && r <= 7) ? 4'b0001 : 4'b0000,
                 (r >= 2 && r <= 3) ? 4'b0001 : 4'b0000, r >= 2 && r <= 7);
            tick();
        end
        // Edges 6 apart: two separate 4-cycle pulses
        for (int r = 0; r < 15; r++) begin
            logic hi;
            hi = (r >= 2 && r <= 5) || (r >= 8 && r <= 11);
            sig_b = (r < 6) ? 4'b0001 : 4'b0000;
            push(cyc + 1, 1'b1, hi ? 4'b0001 : 4'b0000,
                 (r >= 2 && r <= 7) ? 4'b0001 : 4'b0000, hi);
            tick();
        end

        // Test 6: edge counter on ch2 of dut_a
        sig_a = '0;
        repeat (6) tick();
        count_clear = 1'b1; tick(); count_clear = 1'b0;
        chk("ec_cleared", ec_a, 0);
        for (int k = 0; k < 10; k++) begin
            sig_a[2] = ~sig_a[2];
            repeat (3) tick();
        end
        repeat (6) tick();
`ifdef EDGE_COUNT_EN
        chk("ec_10", ec_a, {8'd0, 8'd10, 16'd0});
`else
        chk("ec_10", ec_a, 0);
`endif
        for (int k = 0; k < 290; k++) begin
            sig_a[2] = ~sig_a[2];
            repeat (3) tick();
        end
        repeat (6) tick();
`ifdef EDGE_COUNT_EN
        chk("ec_sat", ec_a, {8'd0, 8'd255, 16'd0});
`else
        chk("ec_sat", ec_a, 0);
`endif
        sig_a[2] = 1'b1;
        repeat (4) tick();
        count_clear = 1'b1;
        tick();
        chk("clr_evt_pulse", 32'(pulse_a[2]), 1);
        chk("clr_wins", ec_a, 0);
        count_clear = 1'b0;
        sig_a[2] = 1'b0;
        tick();
        chk("clr_hold", ec_a, 0);
        repeat (5) tick();
`ifdef EDGE_COUNT_EN
        chk("ec_after_clr", ec_a, {8'd0, 8'd1, 16'd0});
`else
        chk("ec_after_clr", ec_a, 0);
`endif
        chk("ec_b_zero", ec_b, 0);

        // Test 5: asynchronous reset during a dut_b pulse, input held high
        mode_b = 8'b00_00_00_01;
        sig_b = 4'b0001;
        sig_a = 4'b0010;
        repeat (4) tick();
        chk("mid_pulse_b", 32'(pulse_b), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pulse_b", 32'(pulse_b), 0); chk("arst_level_b", 32'(level_b), 0);
        chk("arst_any_b", 32'(any_b), 0);
        chk("arst_pulse_a", 32'(pulse_a), 0); chk("arst_level_a", 32'(level_a), 0);
        chk("arst_ec_a", ec_a, 0);
        for (int r = 0; r < 2; r++) begin
            push(cyc + 1, 1'b0, 4'b0000, 4'b0000, 1'b0);
            push(cyc + 1, 1'b1, 4'b0000, 4'b0000, 1'b0);
            tick();
        end
        reset_n = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            push(cyc + 1, 1'b0, (r == 5) ? 4'b0010 : 4'b0000, (r >= 5) ? 4'b0010 : 4'b0000, r == 5);
            push(cyc + 1, 1'b1, (r >= 3 && r <= 6) ? 4'b0001 : 4'b0000,
                 (r >= 3) ? 4'b0001 : 4'b0000, r >= 3 && r <= 6);
            tick();
        end

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pulse_generator_multi.md
Name: pulse_generator_multi

Overview:
Multi-channel successor to the single-channel falling-edge pulse generator. Each channel does four things:
- synchronises an asynchronous input (trigger/veto/status line) into the clock domain;
- rejects glitches shorter than a programmable stable width;
- detects the edge selected by a per-channel mode;
- emits a retriggerable pulse of programmable length.

It sits at the input boundary of the trigger logic, one instance per group of external lines.

Parameters:
- CHANNELS, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel (legal range 2..4).
- FILTER_LEN, 3, consecutive cycles the synced value must differ from the filtered level before the level changes (legal range 1..255).
- PULSE_LEN, 1, output pulse length in clocks (legal range 1..255).
- CNT_WIDTH, 8, width of each per-channel edge counter (optional feature only).

Ports:
- clock  in  1  system clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset; all flops cleared on assertion.
- signal  in  CHANNELS  asynchronous input lines; bit i is channel i.
- mode  in  2*CHANNELS  per-channel edge select, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
- pulse  out  CHANNELS  registered pulse outputs.
- level  out  CHANNELS  registered filtered level of each input.
- any_pulse  out  1  registered OR of the next-state pulse vector, so it is coincident with pulse.
- count_clear  in  1  synchronous clear of all edge counters.
- edge_count  out  CNT_WIDTH*CHANNELS  per-channel qualifying-edge counters.

Behaviour:
- Reset: while reset_n is 0, every synchroniser flop, filter counter, level, stretch counter, pulse, any_pulse and edge_count is 0. Release is synchronous to clock in the surrounding design; no pulse is produced during reset.
- Synchroniser: shift chain of SYNC_STAGES flops. The synced value s is the last stage.
- Filter (per channel, counter fc, 8 bits):
  - if s == level: fc <= 0.
  - else if fc == FILTER_LEN-1: level <= s, fc <= 0, and an edge event fires (rise if s=1, fall if s=0).
  - else: fc <= fc+1.
  - Any cycle where s returns to level restarts the count.
- Qualification: an edge event is qualifying if mode[2i+1:2i] permits that edge. mode is sampled in the same cycle as the event; mode changes have no other effect. Mode 00 still tracks level.
- Latency: input change stable before capture edge 1 → level and pulse change on edge SYNC_STAGES+FILTER_LEN (edge 5 at defaults).
- Stretch (per channel, counter sc, 8 bits):
  - on a qualifying event, sc <= PULSE_LEN-1 and pulse <= 1;
  - else if sc != 0, sc <= sc-1 and pulse stays 1;
  - else pulse <= 0.
  - A qualifying event during an active pulse reloads sc (retrigger), so the pulse is extended, never split.
  - With PULSE_LEN=1, back-to-back events give continuous high.
- Reset mid-operation: pulse drops immediately and asynchronously. level returns to 0, so an input held high through reset release yields a rising event after the normal latency.
- Channels are fully independent; simultaneous events on several channels are each honoured.

Optional Feature:
Macro EDGE_COUNT_EN.
- Defined:
  - each channel has a CNT_WIDTH counter that increments on every qualifying event and saturates at all-ones;
  - count_clear zeroes all counters;
  - count_clear coincident with an event gives 0 (clear wins);
  - edge_count bits [CNT_WIDTH*(i+1)-1 : CNT_WIDTH*i] hold channel i.
- Not defined: edge_count is constant 0, count_clear is ignored, and the ports remain so the interface is unchanged.

Test Plan:
1. Defaults, ch0 mode=10, signal[0] held 1 for 20 cycles, then 0 before edge k+1 → level[0] falls and pulse[0]=1 for exactly one cycle at edge k+5; any_pulse matches. Other channels stay 0.
2. ch1 mode=01, signal[1] high for 2 cycles then low → no pulse, level[1] stays 0. Repeat with 3 cycles high → pulse[1] rise pulse, then level[1] returns 0 with no second pulse.
3. mode=11, PULSE_LEN=4, FILTER_LEN=1, rise then fall 2 cycles apart → pulse high 6 contiguous cycles (retrigger); with a 6-cycle gap → two separate 4-cycle pulses.
4. All four channels toggle on the same cycle with mode=11 → all pulse bits assert on the same edge; mode=00 channel stays 0 while its level tracks.
5. reset_n asserted mid-pulse with input held 1 → pulse, level and counters go 0 without waiting for a clock; after release, a rising pulse appears SYNC_STAGES+FILTER_LEN edges later (mode 01).
6. EDGE_COUNT_EN, CNT_WIDTH=8, 300 qualifying edges on ch2 → edge_count[23:16]=255 (saturated); count_clear pulsed together with an event → reads 0. Without the macro → edge_count is all 0 throughout.
